// File: rtl/bg_draw_pkg.sv
// Shared constants and types for the scrolling background renderer.
// Colours are packed RRRGGGBB.
package bg_draw_pkg;

    localparam logic [7:0] SKY_COLOR    = 8'h5F;
    localparam logic [7:0] GROUND_COLOR = 8'h8C;
    localparam logic [7:0] BORDER_COLOR = 8'hFC;

    localparam int unsigned MODE_SCROLL_BIT = 0;
    localparam int unsigned MODE_BLINK_BIT  = 1;

    localparam int BAR_WIDTH = 512;

    // Region flags and palette index captured in the first pipeline stage
    typedef struct packed {
        logic       active;
        logic       border;
        logic       bar;
        logic       ground;
        logic [7:0] idx;
    } stage1_t;

endpackage

// File: rtl/background_scroll_draw_if.sv
// Pixel-position / colour bus between the video timing source and the background renderer.
interface background_scroll_draw_if;

    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic [1:0]  mode;
    logic        freeze;
    logic [7:0]  BG_RGB;
    logic        boardersDrawReq;

    modport master (
        output pixelX, pixelY, startOfFrame, mode, freeze,
        input  BG_RGB, boardersDrawReq
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, mode, freeze,
        output BG_RGB, boardersDrawReq
    );

endinterface

// File: rtl/bg_frame_ctrl.sv
// Frame-rate state: mode latch, scroll divider and offset, blink counter and phase.
// Wrap decisions use the mode latched at the previous startOfFrame, i.e. the mode of the frame just ending.
module bg_frame_ctrl
    import bg_draw_pkg::*;
#(
    parameter int SCROLL_DIV   = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_sof,
    input  logic [1:0] i_mode,
    input  logic       i_freeze,
    output logic [8:0] o_scroll_off,
    output logic       o_blink_off
);

    localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [1:0]       r_mode;
    logic [DIV_W-1:0] r_div;
    logic [BLK_W-1:0] r_blink_cnt;
    logic [8:0]       r_scroll;
    logic             r_blink_on;
    logic             w_div_wrap;
    logic             w_blink_wrap;

    assign w_div_wrap   = (r_div == DIV_W'(SCROLL_DIV - 1));
    assign w_blink_wrap = (r_blink_cnt == BLK_W'(BLINK_FRAMES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode      <= '0;
            r_div       <= '0;
            r_blink_cnt <= '0;
            r_scroll    <= '0;
            r_blink_on  <= 1'b1;
        end else if (i_sof) begin
            r_mode <= i_mode;
            if (!i_freeze) begin
                r_div       <= w_div_wrap   ? '0 : r_div + DIV_W'(1);
                r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + BLK_W'(1);
                if (w_div_wrap && r_mode[MODE_SCROLL_BIT])
                    r_scroll <= r_scroll + 9'd2;
                if (!r_mode[MODE_BLINK_BIT])
                    r_blink_on <= 1'b1;
                else if (w_blink_wrap)
                    r_blink_on <= ~r_blink_on;
            end
        end
    end

    assign o_scroll_off = r_scroll;
    assign o_blink_off  = r_mode[MODE_BLINK_BIT] & ~r_blink_on;

endmodule

// File: rtl/background_scroll_draw.sv
// Background renderer: palette bar, blinking border, ground and sky, two-cycle registered output.
module background_scroll_draw
    import bg_draw_pkg::*;
#(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BO           = 32,
    parameter int BW           = 8,
    parameter int BAR_TOP      = 5,
    parameter int BAR_BOTTOM   = 19,
    parameter int BAR_LEFT     = 30,
    parameter int GROUND_Y     = 400,
    parameter int SCROLL_DIV   = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                     clk,
    input  logic                     reset,
    background_scroll_draw_if.slave  bus
);

    localparam logic [10:0] H_MAX    = 11'(H_ACTIVE);
    localparam logic [10:0] V_MAX    = 11'(V_ACTIVE);
    localparam logic [10:0] XB_L0    = 11'(BO - BW);
    localparam logic [10:0] XB_H0    = 11'(BO);
    localparam logic [10:0] XB_L1    = 11'(H_ACTIVE - 1 - BO);
    localparam logic [10:0] XB_H1    = 11'(H_ACTIVE - 1 - BO + BW);
    localparam logic [10:0] YB_L0    = 11'(BO - BW);
    localparam logic [10:0] YB_H0    = 11'(BO);
    localparam logic [10:0] YB_L1    = 11'(V_ACTIVE - 1 - BO);
    localparam logic [10:0] YB_H1    = 11'(V_ACTIVE - 1 - BO + BW);
    localparam logic [10:0] BAR_X_LO = 11'(BAR_LEFT);
    localparam logic [10:0] BAR_X_HI = 11'(BAR_LEFT + BAR_WIDTH - 1);
    localparam logic [10:0] BAR_Y_LO = 11'(BAR_TOP);
    localparam logic [10:0] BAR_Y_HI = 11'(BAR_BOTTOM);
    localparam logic [10:0] GND_Y    = 11'(GROUND_Y);
    localparam logic [8:0]  BAR_X_LO9 = BAR_X_LO[8:0];

    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [8:0]  w_scroll;
    logic        w_blink_off;
    logic [8:0]  w_rel;
    stage1_t     w_s1;
    stage1_t     r_s1;
    logic [7:0]  w_rgb;
    logic [7:0]  r_rgb;
    logic        r_bdr;

    assign w_x = bus.pixelX;
    assign w_y = bus.pixelY;

    bg_frame_ctrl #(
        .SCROLL_DIV   (SCROLL_DIV),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_frame_ctrl (
        .clk          (clk),
        .reset        (reset),
        .i_sof        (bus.startOfFrame),
        .i_mode       (bus.mode),
        .i_freeze     (bus.freeze),
        .o_scroll_off (w_scroll),
        .o_blink_off  (w_blink_off)
    );

    // 9-bit arithmetic gives the mod-512 wrap of the palette position for free
    assign w_rel = w_x[8:0] - BAR_X_LO9 + w_scroll;

    always_comb begin
        w_s1        = '0;
        w_s1.active = (w_x < H_MAX) && (w_y < V_MAX);
        w_s1.border = (w_x >= XB_L0 && w_x <= XB_H0) || (w_x >= XB_L1 && w_x <= XB_H1) ||
                      (w_y >= YB_L0 && w_y <= YB_H0) || (w_y >= YB_L1 && w_y <= YB_H1);
        w_s1.bar    = (w_y >= BAR_Y_LO && w_y <= BAR_Y_HI) &&
                      (w_x >= BAR_X_LO && w_x <= BAR_X_HI);
        w_s1.ground = (w_y >= GND_Y);
        w_s1.idx    = 8'(w_rel >> 1);
    end

    always_ff @(posedge clk) begin
        if (reset) r_s1 <= '0;
        else       r_s1 <= w_s1;
    end

    always_comb begin
        w_rgb = '0;
        if (r_s1.active) begin
            if (r_s1.bar)         w_rgb = r_s1.idx;
            else if (r_s1.border) w_rgb = w_blink_off ? SKY_COLOR : BORDER_COLOR;
            else if (r_s1.ground) w_rgb = GROUND_COLOR;
            else                  w_rgb = SKY_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb <= '0;
            r_bdr <= 1'b0;
        end else begin
            r_rgb <= w_rgb;
            r_bdr <= r_s1.active & r_s1.border;
        end
    end

    assign bus.BG_RGB          = r_rgb;
    assign bus.boardersDrawReq = r_bdr;

endmodule

// File: tb/tb_background_scroll_draw.sv
// Randomized and directed checks of background_scroll_draw against a behavioural frame/pixel model.
module tb_background_scroll_draw;

    localparam int C_SKY    = 8'h5F;
    localparam int C_GROUND = 8'h8C;
    localparam int C_BORDER = 8'hFC;

    logic clk;
    logic reset;
    background_scroll_draw_if bus ();

    background_scroll_draw dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Model state
    int m_scroll;
    int m_frames;
    bit m_blink_on;
    bit [1:0] m_mode;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        m_scroll   = 0;
        m_frames   = 0;
        m_blink_on = 1'b1;
        m_mode     = 2'b00;
    endfunction

    function automatic void model_sof(input bit [1:0] mode, input bit frz);
        if (!frz) begin
            m_frames++;
            if ((m_frames % 2) == 0 && m_mode[0]) m_scroll = (m_scroll + 2) % 512;
            if (!m_mode[1]) m_blink_on = 1'b1;
            else if ((m_frames % 30) == 0) m_blink_on = !m_blink_on;
        end
        m_mode = mode;
    endfunction

    // Returns {boardersDrawReq, BG_RGB}
    function automatic int model_pix(input int x, input int y);
        bit border, bar;
        int rgb;
        if (x >= 640 || y >= 480) return 0;
        border = (x >= 24 && x <= 32) || (x >= 607 && x <= 615) ||
                 (y >= 24 && y <= 32) || (y >= 447 && y <= 455);
        bar = (y >= 5 && y <= 19) && (x >= 30 && x <= 541);
        if (bar)         rgb = ((x - 30 + m_scroll) % 512) / 2;
        else if (border) rgb = (m_mode[1] && !m_blink_on) ? C_SKY : C_BORDER;
        else if (y >= 400) rgb = C_GROUND;
        else             rgb = C_SKY;
        return (int'(border) << 8) | rgb;
    endfunction

    task automatic sof(input bit [1:0] mode, input bit frz);
        bus.mode         = mode;
        bus.freeze       = frz;
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        bus.freeze       = 1'b0;
        model_sof(mode, frz);
    endtask

    task automatic pix(input string tag, input int x, input int y);
        int e;
        bus.pixelX = 11'(x);
        bus.pixelY = 11'(y);
        e = model_pix(x, y);
        tick();
        tick();
        chk({tag, ".rgb"}, int'(bus.BG_RGB), e & 8'hFF);
        chk({tag, ".bdr"}, int'(bus.boardersDrawReq), e >> 8);
    endtask

    task automatic rand_xy(output int x, output int y);
        case ($urandom % 4)
            0: begin x = $urandom_range(0, 799);  y = $urandom_range(0, 524); end
            1: begin x = $urandom_range(20, 560); y = $urandom_range(3, 21);  end
            2: begin
                x = ($urandom % 2) ? $urandom_range(20, 36) : $urandom_range(603, 619);
                y = $urandom_range(0, 479);
            end
            default: begin x = $urandom_range(0, 660); y = $urandom_range(396, 460); end
        endcase
    endtask

    // Back-to-back pixels; mode input is wiggled mid-frame and must have no effect
    task automatic run_burst(input int n);
        int q[$];
        int x, y, e;
        for (int k = 0; k <= n; k++) begin
            if (k < n) begin
                rand_xy(x, y);
                bus.pixelX = 11'(x);
                bus.pixelY = 11'(y);
                bus.mode   = 2'($urandom);
                q.push_back(model_pix(x, y));
            end
            tick();
            if (k >= 1) begin
                e = q.pop_front();
                chk("burst.rgb", int'(bus.BG_RGB), e & 8'hFF);
                chk("burst.bdr", int'(bus.boardersDrawReq), e >> 8);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset            = 1'b1;
        bus.pixelX       = '0;
        bus.pixelY       = '0;
        bus.startOfFrame = 1'b0;
        bus.mode         = '0;
        bus.freeze       = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("reset.rgb", int'(bus.BG_RGB), 0);
        chk("reset.bdr", int'(bus.boardersDrawReq), 0);
        reset = 1'b0;

        pix("border_left", 28, 100);
        chk("border_left.const", int'(bus.BG_RGB), C_BORDER);
        pix("bar_first", 30, 10);
        pix("bar_last", 541, 10);
        chk("bar_last.const", int'(bus.BG_RGB), 8'hFF);
        pix("bar_edge_border", 29, 10);
        pix("offscreen", 700, 10);
        pix("ground", 300, 420);
        pix("sky", 300, 200);

        repeat (4) sof(2'b01, 1'b0);
        pix("scroll4", 30, 10);
        chk("scroll4.const", int'(bus.BG_RGB), 8'h02);
        repeat (512) sof(2'b01, 1'b0);
        pix("scroll_wrap", 30, 10);
        chk("scroll_wrap.const", int'(bus.BG_RGB), 8'h02);
        pix("scroll_wrap_hi", 540, 19);

        // Mid-line reset with a coincident startOfFrame that must be ignored
        bus.pixelX = 11'd28;
        bus.pixelY = 11'd100;
        tick();
        tick();
        reset = 1'b1;
        bus.startOfFrame = 1'b1;
        bus.mode = 2'b11;
        tick();
        chk("rst_mid.rgb", int'(bus.BG_RGB), 0);
        chk("rst_mid.bdr", int'(bus.boardersDrawReq), 0);
        tick();
        reset = 1'b0;
        bus.startOfFrame = 1'b0;
        model_reset();
        tick();
        chk("rst_flush.rgb", int'(bus.BG_RGB), 0);
        tick();
        chk("rst_first.rgb", int'(bus.BG_RGB), C_BORDER);
        chk("rst_first.bdr", int'(bus.boardersDrawReq), 1);
        pix("rst_scroll", 30, 10);

        repeat (30) sof(2'b10, 1'b0);
        pix("blink_off", 28, 100);
        chk("blink_off.const", int'(bus.BG_RGB), C_SKY);
        pix("blink_off_bar", 31, 10);
        repeat (30) sof(2'b10, 1'b0);
        pix("blink_on", 28, 100);
        chk("blink_on.const", int'(bus.BG_RGB), C_BORDER);

        repeat (37) sof(2'b11, 1'b0);
        pix("pre_freeze_bar", 30, 10);
        pix("pre_freeze_bdr", 28, 100);
        repeat (10) sof(2'b11, 1'b1);
        pix("freeze_bar", 30, 10);
        pix("freeze_bdr", 28, 100);

        bus.mode = 2'b00;
        tick();
        pix("midframe_mode", 28, 100);
        sof(2'b00, 1'b0);
        sof(2'b00, 1'b0);
        pix("blink_forced_on", 28, 100);

        for (int r = 0; r < 40; r++) begin
            int nf;
            nf = $urandom_range(0, 6);
            for (int f = 0; f < nf; f++)
                sof(2'($urandom), ($urandom % 4) == 0);
            run_burst(16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/background_scroll_draw.md
BACKGROUND_SCROLL_DRAW -- requirements
Module: background_scroll_draw

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 Parameters BO / BW, defaults 32 / 8, bracket offset and bracket width in pixels.
REQ-004 Parameters BAR_TOP / BAR_BOTTOM / BAR_LEFT, defaults 5 / 19 / 30, palette bar rows (inclusive) and first column; bar width is fixed at 512.
REQ-005 Parameter GROUND_Y, default 400, first ground row.
REQ-006 Parameters SCROLL_DIV / BLINK_FRAMES, defaults 2 / 30, frames per scroll step and frames per blink phase.
REQ-007 clk  in  1  single clock; all logic on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 pixelX  in  11  current pixel column.
REQ-010 pixelY  in  11  current pixel row.
REQ-011 startOfFrame  in  1  one-cycle pulse before pixel (0,0) of each frame.
REQ-012 mode  in  2  bit0 scroll enable, bit1 blink enable.
REQ-013 freeze  in  1  holds scroll and blink state while high.
REQ-014 BG_RGB  out  8  pixel colour, packed RRRGGGBB.
REQ-015 boardersDrawReq  out  1  high when the pixel lies in a border band.

Function
REQ-016 BG_RGB and boardersDrawReq SHALL be registered outputs with exactly 2 cycles latency from pixelX/pixelY; stage 1 registers region flags and palette index, stage 2 registers colour.
REQ-017 Border region SHALL be x in [BO-BW, BO], or x in [H_ACTIVE-1-BO, H_ACTIVE-1-BO+BW], or y in [BO-BW, BO], or y in [V_ACTIVE-1-BO, V_ACTIVE-1-BO+BW], all inclusive.
REQ-018 Bar region SHALL be y in [BAR_TOP, BAR_BOTTOM] and x in [BAR_LEFT, BAR_LEFT+511].
REQ-019 Palette index SHALL be (((pixelX-BAR_LEFT)+scrollOff) mod 512)>>1, 8 bits, emitted directly as BG_RGB.
REQ-020 Colour priority SHALL be bar > border > ground (y >= GROUND_Y) > sky.
REQ-021 Border colour SHALL be BORDER_COLOR, or SKY_COLOR during the off phase while blink is active.
REQ-022 boardersDrawReq SHALL follow the border region only, independent of bar overlap and blink phase.
REQ-023 Pixels with x >= H_ACTIVE or y >= V_ACTIVE SHALL give BG_RGB=0 and boardersDrawReq=0.
REQ-024 mode SHALL be sampled only on startOfFrame; mid-frame changes take effect from the next frame.
REQ-025 A frame divider SHALL count startOfFrame pulses 0..SCROLL_DIV-1 and wrap.
REQ-026 On the wrap, with latched mode bit0=1 and freeze=0, scrollOff SHALL advance by 2 modulo 512, which shifts the palette by one colour.
REQ-027 A blink counter SHALL count frames 0..BLINK_FRAMES-1; on each wrap with latched mode bit1=1 and freeze=0, the blink phase SHALL toggle.
REQ-028 While freeze=1, both counters, scrollOff and the blink phase SHALL hold.
REQ-029 startOfFrame coinciding with reset SHALL be ignored.
REQ-030 When blink is disabled, the blink phase SHALL be forced to on at the next startOfFrame.

Reset
REQ-031 reset SHALL clear both pipeline stages and set BG_RGB=0 and boardersDrawReq=0 on the next edge.
REQ-032 reset SHALL clear scrollOff, the divider, the blink counter and latched mode to 0, and set the blink phase to on.
REQ-033 Reset mid-frame SHALL leave no residual pipeline data; the first valid colour appears 2 cycles after reset falls.

Structure
REQ-034 Package bg_draw_pkg SHALL hold SKY_COLOR, GROUND_COLOR, BORDER_COLOR, the mode bit positions and the 512 bar width.
REQ-035 Frame-rate state (mode latch, divider, scrollOff, blink) SHALL live in sub-module bg_frame_ctrl; background_scroll_draw instantiates it once.

Verification
REQ-036 Default params, mode=0, pixel (28,100) -> 2 cycles later BG_RGB=BORDER_COLOR, boardersDrawReq=1.
REQ-037 Pixel (30,10), scrollOff=0 -> BG_RGB=8'h00; pixel (541,10) -> BG_RGB=8'hFF; pixel (29,10) -> border colour, not palette.
REQ-038 mode=01, 4 startOfFrame pulses -> scrollOff=4; pixel (30,10) -> BG_RGB=8'h02; after 512 further pulses scrollOff wraps to 4.
REQ-039 mode=10, 30 frames -> pixel (28,100) gives SKY_COLOR with boardersDrawReq=1; after 30 more frames -> BORDER_COLOR.
REQ-040 freeze=1 across 10 frames -> scrollOff and blink phase unchanged; mode changed mid-frame -> no effect until the next startOfFrame.
REQ-041 reset pulsed mid-line -> outputs 0 on the next edge; pixel (700,10) -> BG_RGB=0 and boardersDrawReq=0.
